mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 150 +++++++++++++++
 tb/tb_mem_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: turns load/store instructions into single-outstanding memory requests,
// formats load data, flags misaligned/illegal/timed-out accesses and stalls upstream meanwhile.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_regb,
    input  logic        ex_mem_rd_mem,
    input  logic        ex_mem_wr_mem,
    input  logic [2:0]  ex_mem_funct3,
    input  logic        ex_mem_valid_inst,
    input  logic        mem2proc_ack,
    input  logic [31:0] mem2proc_data,
    output logic        proc2mem_req,
    output logic        proc2mem_we,
    output logic [31:0] proc2mem_addr,
    output logic [31:0] proc2mem_data,
    output logic [3:0]  proc2mem_be,
    output logic [31:0] mem_result_out,
    output logic        mem_stall_out,
    output logic        mem_error_out
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [31:0] count;
    logic [31:0] cap;

    logic        mem_op;
    logic [1:0]  lane;
    logic        illegal;
    logic        timeout;
    logic        err_now;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    always_comb begin
        mem_op  = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);
        lane    = ex_mem_alu_result[1:0];
        illegal = 1'b0;
        if (ex_mem_rd_mem && ex_mem_wr_mem) begin
            illegal = 1'b1;
        end else if (ex_mem_rd_mem) begin
            case (ex_mem_funct3)
                3'b000, 3'b100: illegal = 1'b0;
                3'b001, 3'b101: illegal = lane[0];
                3'b010:         illegal = (lane != 2'b00);
                default:        illegal = 1'b1;
            endcase
        end else begin
            case (ex_mem_funct3)
                3'b000:  illegal = 1'b0;
                3'b001:  illegal = lane[0];
                3'b010:  illegal = (lane != 2'b00);
                default: illegal = 1'b1;
            endcase
        end

        // Ack in the final counted cycle still completes the access.
        timeout = (state == REQ) && !mem2proc_ack && (count == TIMEOUT);
        err_now = !rst && (((state == IDLE) && mem_op && illegal) || timeout);

        case (ex_mem_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{ex_mem_regb[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << lane;
                st_data = {2{ex_mem_regb[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = ex_mem_regb;
            end
        endcase

        case (lane)
            2'b00:   ld_byte = cap[7:0];
            2'b01:   ld_byte = cap[15:8];
            2'b10:   ld_byte = cap[23:16];
            default: ld_byte = cap[31:24];
        endcase
        ld_half = lane[1] ? cap[31:16] : cap[15:0];

        case (ex_mem_funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = cap;
        endcase

        mem_error_out = err_now;
        mem_stall_out = mem_op && (state != DONE) && !err_now;
        if (!mem_op)
            mem_result_out = ex_mem_alu_result;
        else if ((state == DONE) && ex_mem_rd_mem && !err_now)
            mem_result_out = ld_val;
        else
            mem_result_out = 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= 32'd0;
            cap           <= 32'd0;
            proc2mem_req  <= 1'b0;
            proc2mem_we   <= 1'b0;
            proc2mem_addr <= 32'd0;
            proc2mem_data <= 32'd0;
            proc2mem_be   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !illegal) begin
                        state         <= REQ;
                        count         <= 32'd0;
                        proc2mem_req  <= 1'b1;
                        proc2mem_we   <= ex_mem_wr_mem;
                        proc2mem_addr <= {ex_mem_alu_result[31:2], 2'b00};
                        proc2mem_data <= st_data;
                        proc2mem_be   <= ex_mem_wr_mem ? st_be : 4'b1111;
                    end
                end
                REQ: begin
                    if (mem2proc_ack) begin
                        cap          <= mem2proc_data;
                        state        <= DONE;
                        proc2mem_req <= 1'b0;
                    end else if (timeout) begin
                        state        <= IDLE;
                        proc2mem_req <= 1'b0;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model of the memory stage.
module tb_mem_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu, regb, mdata;
    logic        rd, wr, vld, ack;
    logic [2:0]  f3;
    logic        req, we, stall, err;
    logic [31:0] paddr, pdata, result;
    logic [3:0]  be;

    int n_chk = 0;
    int n_pass = 0;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_alu_result(alu), .ex_mem_regb(regb),
        .ex_mem_rd_mem(rd), .ex_mem_wr_mem(wr),
        .ex_mem_funct3(f3), .ex_mem_valid_inst(vld),
        .mem2proc_ack(ack), .mem2proc_data(mdata),
        .proc2mem_req(req), .proc2mem_we(we),
        .proc2mem_addr(paddr), .proc2mem_data(pdata), .proc2mem_be(be),
        .mem_result_out(result), .mem_stall_out(stall), .mem_error_out(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic legal(input logic l, input logic s, input logic [2:0] f, input logic [31:0] a);
        int size;
        size = int'(f[1:0]);
        if (l && s) return 1'b0;
        if (l && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b0;
        if (s && f > 3'd2) return 1'b0;
        return (a % (32'd1 << size)) == 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        case (f)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // One instruction; ack arrives dly cycles after the first request cycle (dly > TMO: never).
    task automatic run_op(input logic l, input logic s, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input int dly, input logic [31:0] rdat);
        logic [3:0]  ebe;
        logic [31:0] edat;
        int          size;
        logic        done;
        size = int'(f[1:0]);
        ebe  = s ? ((size == 2) ? 4'hF : ((4'((1 << (1 << size)) - 1)) << a[1:0])) : 4'hF;
        edat = (size == 0) ? {4{wd[7:0]}} : (size == 1) ? {2{wd[15:0]}} : wd;
        @(negedge clk);
        vld = 1'b1; rd = l; wr = s; f3 = f; alu = a; regb = wd; ack = 1'b0; mdata = $urandom;
        #1;
        chk("idle_req", {31'd0, req}, 32'd0);
        if (!legal(l, s, f, a)) begin
            chk("bad_err", {31'd0, err}, 32'd1);
            chk("bad_stall", {31'd0, stall}, 32'd0);
            chk("bad_result", result, 32'd0);
            return;
        end
        chk("op_stall", {31'd0, stall}, 32'd1);
        chk("op_err", {31'd0, err}, 32'd0);
        done = 1'b0;
        for (int c = 0; c <= TMO; c++) begin
            @(negedge clk);
            ack = (c == dly);
            mdata = ack ? rdat : $urandom;
            #1;
            chk("req", {31'd0, req}, 32'd1);
            chk("we", {31'd0, we}, {31'd0, s});
            chk("addr", paddr, {a[31:2], 2'b00});
            chk("be", {28'd0, be}, {28'd0, ebe});
            if (s) chk("wdata", pdata, edat);
            if (ack) begin
                chk("ack_stall", {31'd0, stall}, 32'd1);
                done = 1'b1;
                break;
            end else if (c == TMO) begin
                chk("tmo_err", {31'd0, err}, 32'd1);
                chk("tmo_stall", {31'd0, stall}, 32'd0);
                chk("tmo_result", result, 32'd0);
            end else begin
                chk("wait_stall", {31'd0, stall}, 32'd1);
                chk("wait_err", {31'd0, err}, 32'd0);
            end
        end
        if (done) begin
            @(negedge clk);
            ack = 1'b0; mdata = $urandom;
            #1;
            chk("done_stall", {31'd0, stall}, 32'd0);
            chk("done_err", {31'd0, err}, 32'd0);
            chk("done_req", {31'd0, req}, 32'd0);
            chk("done_result", result, s ? 32'd0 : load_val(f, a, rdat));
        end
    endtask

    task automatic non_mem(input logic [31:0] a);
        @(negedge clk);
        vld = $urandom_range(0, 1); rd = 1'b0; wr = 1'b0; f3 = 3'($urandom);
        alu = a; ack = $urandom_range(0, 1); mdata = $urandom;
        #1;
        chk("pass_result", result, a);
        chk("pass_stall", {31'd0, stall}, 32'd0);
        chk("pass_err", {31'd0, err}, 32'd0);
        chk("pass_req", {31'd0, req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; rd = 1'b0; wr = 1'b0; f3 = 3'd0;
        alu = 32'd0; regb = 32'd0; ack = 1'b0; mdata = 32'd0;
        #12;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_addr", paddr, 32'd0);
        chk("rst_be", {28'd0, be}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1, 0, 3'd2, 32'h100, 32'h0, 2, 32'hDEADBEEF);
        run_op(1, 0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF0000);
        run_op(1, 0, 3'd4, 32'h103, 32'h0, 1, 32'h80FF0000);
        run_op(1, 0, 3'd5, 32'h102, 32'h0, 0, 32'h80FF0000);
        run_op(0, 1, 3'd0, 32'h201, 32'hA5, 0, 32'h0);
        run_op(0, 1, 3'd1, 32'h202, 32'h1234, 3, 32'h0);
        run_op(1, 0, 3'd2, 32'h102, 32'h0, 0, 32'h0);
        non_mem(32'h55);
        run_op(1, 0, 3'd2, 32'h300, 32'h0, TMO + 2, 32'h0);
        run_op(0, 1, 3'd2, 32'h304, 32'hCAFEF00D, TMO, 32'h0);
        run_op(1, 1, 3'd0, 32'h10, 32'h0, 0, 32'h0);

        // Reset while a request is outstanding, then a stale ack.
        @(negedge clk);
        vld = 1'b1; rd = 1'b1; wr = 1'b0; f3 = 3'd2; alu = 32'h40; ack = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_req", {31'd0, req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, req}, 32'd0);
        chk("mid_rst_addr", paddr, 32'd0);
        chk("mid_rst_we", {31'd0, we}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0; vld = 1'b0; rd = 1'b0; alu = 32'h77; ack = 1'b1; mdata = 32'h12345678;
        #1;
        chk("late_ack_result", result, 32'h77);
        chk("late_ack_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("late_ack_req", {31'd0, req}, 32'd0);
        run_op(1, 0, 3'd2, 32'h40, 32'h0, 0, 32'h0BADF00D);

        for (int i = 0; i < 300; i++) begin
            int      kind;
            logic    l, s;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a = $urandom;
            if (kind == 0) begin
                non_mem(a);
            end else begin
                l = (kind <= 5) || (kind == 9);
                s = (kind > 5);
                run_op(l, s, 3'($urandom), a, $urandom, $urandom_range(0, TMO + 2), $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
